// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file write-side controller.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Candidate qualifies for forwarding; callers scan oldest to youngest so the last hit wins.
  function automatic logic youngest_match(input wb_entry_t cand, input logic [ADDR_W-1:0] rq_addr);
    return cand.valid && (cand.addr == rq_addr) && (rq_addr != '0);
  endfunction

endpackage

// File: rtl/regfile_write_ctrl_wb_fifo.sv
// Circular write-back buffer with occupancy count and an age-ordered view for lookups.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_push,
  input  logic [ADDR_W-1:0]         i_addr,
  input  logic [DATA_W-1:0]         i_data,
  input  logic                      i_pop,
  input  logic                      i_flush,
  output logic [$clog2(DEPTH):0]    o_count,
  output wb_entry_t [DEPTH-1:0]     o_view
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (i_pop) begin
        r_head          <= r_head + PTR_W'(1);
        r_valid[r_head] <= 1'b0;
      end
      if (i_push) begin
        r_tail          <= r_tail + PTR_W'(1);
        r_valid[r_tail] <= 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is deliberately left unreset; the valid flags gate visibility.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_addr_mem[r_tail] <= i_addr;
      r_data_mem[r_tail] <= i_data;
    end
  end

  // View index 0 is the head (oldest), DEPTH-1 the youngest slot.
  always_comb begin
    o_view = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      o_view[k].valid = r_valid[r_head + PTR_W'(k)];
      o_view[k].addr  = r_addr_mem[r_head + PTR_W'(k)];
      o_view[k].data  = r_data_mem[r_head + PTR_W'(k)];
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write controller: buffers write-backs, drains to the write port, forwards pending data.
module regfile_write_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_data,
  input  logic                   wb_stall,
  input  logic                   flush,
  output logic                   we,
  output logic [ADDR_W-1:0]      wa,
  output logic [DATA_W-1:0]      wd,
  input  logic [ADDR_W-1:0]      rq_addr1,
  input  logic [ADDR_W-1:0]      rq_addr2,
  output logic                   rq_hit1,
  output logic                   rq_hit2,
  output logic [DATA_W-1:0]      rq_data1,
  output logic [DATA_W-1:0]      rq_data2,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             dropped
);

  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [7:0]  DROP_MAX = 8'hFF;

  logic                  w_accept;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_count;
  wb_entry_t [DEPTH-1:0] w_view;
  wb_entry_t             w_out;
  wb_entry_t [DEPTH:0]   w_cands;

  logic                  r_we;
  logic [ADDR_W-1:0]     r_wa;
  logic [DATA_W-1:0]     r_wd;
  logic [7:0]            r_dropped;

  assign req_ready = (w_count < CNT_W'(DEPTH)) && !flush;
  assign w_accept  = req_valid && req_ready;
  assign w_push    = w_accept && (req_addr != '0);
  assign w_drop    = w_accept && (req_addr == '0);
  assign w_pop     = (w_count != '0) && !wb_stall && !flush;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_addr  (req_addr),
    .i_data  (req_data),
    .i_pop   (w_pop),
    .i_flush (flush),
    .o_count (w_count),
    .o_view  (w_view)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we      <= 1'b0;
      r_wa      <= '0;
      r_wd      <= '0;
      r_dropped <= '0;
    end else begin
      r_we <= w_pop;
      if (w_pop) begin
        r_wa <= w_view[0].addr;
        r_wd <= w_view[0].data;
      end
      if (w_drop && (r_dropped != DROP_MAX)) begin
        r_dropped <= r_dropped + 8'd1;
      end
    end
  end

  // Candidate 0 is the output register (oldest); FIFO entries follow in age order.
  assign w_out   = '{valid: r_we, addr: r_wa, data: r_wd};
  assign w_cands = {w_view, w_out};

  function automatic logic [DATA_W:0] f_lookup(input wb_entry_t [DEPTH:0] cands,
                                               input logic [ADDR_W-1:0]   rq);
    logic [DATA_W:0] res;
    res = '0;
    for (int unsigned i = 0; i <= DEPTH; i++) begin
      if (youngest_match(cands[i], rq)) begin
        res = {1'b1, cands[i].data};
      end
    end
    return res;
  endfunction

  assign {rq_hit1, rq_data1} = f_lookup(w_cands, rq_addr1);
  assign {rq_hit2, rq_data2} = f_lookup(w_cands, rq_addr2);

  assign we      = r_we;
  assign wa      = r_wa;
  assign wd      = r_wd;
  assign count   = w_count;
  assign dropped = r_dropped;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl: stimulus queues expected writes, a monitor checks each we pulse.
module tb_regfile_write_ctrl;
  import regfile_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              wb_stall;
  logic              flush;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] rq_addr1;
  logic [ADDR_W-1:0] rq_addr2;
  logic              rq_hit1;
  logic              rq_hit2;
  logic [DATA_W-1:0] rq_data1;
  logic [DATA_W-1:0] rq_data2;
  logic [$clog2(DEPTH):0] count;
  logic [7:0]        dropped;

  logic [ADDR_W+DATA_W-1:0] sb_q[$];
  logic [ADDR_W+DATA_W-1:0] mon_e;
  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  regfile_write_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .wb_stall(wb_stall), .flush(flush),
    .we(we), .wa(wa), .wd(wd),
    .rq_addr1(rq_addr1), .rq_addr2(rq_addr2),
    .rq_hit1(rq_hit1), .rq_hit2(rq_hit2), .rq_data1(rq_data1), .rq_data2(rq_data2),
    .count(count), .dropped(dropped)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && we) begin
      if (sb_q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_we: got wa=%0d wd=0x%0h, expected no write", wa, wd);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wb_addr", 32'(wa), 32'(mon_e[DATA_W +: ADDR_W]));
        chk("wb_data", wd, mon_e[DATA_W-1:0]);
      end
    end
  end

  task automatic do_push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_tot++;
      $display("FAIL push_timeout: req_ready=0 for addr %0d, expected 1", a);
      req_valid = 1'b0;
      return;
    end
    if (a != '0) sb_q.push_back({a, d});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
    wb_stall = 1'b0; flush = 1'b0; rq_addr1 = '0; rq_addr2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wa", 32'(wa), 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);

    // Single write, two-edge latency, one-cycle pulse.
    do_push(5'd5, 32'hDEADBEEF);
    chk("t1_count_after_accept", 32'(count), 32'd1);
    @(negedge clk); chk("t1_we_edge1", 32'(we), 32'd0);
    @(negedge clk); chk("t1_we_edge2", 32'(we), 32'd1);
    chk("t1_wa", 32'(wa), 32'd5);
    chk("t1_count_drained", 32'(count), 32'd0);
    @(negedge clk); chk("t1_we_edge3", 32'(we), 32'd0);

    // Fill under stall, then burst drain.
    @(negedge clk) wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) do_push(ADDR_W'(i), 32'h100 + 32'(i));
    chk("t2_ready_full", 32'(req_ready), 32'd0);
    chk("t2_count_full", 32'(count), 32'd4);
    @(negedge clk) wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t2_burst_we", 32'(we), 32'd1);
    end
    @(negedge clk);
    chk("t2_we_after", 32'(we), 32'd0);
    chk("t2_count_empty", 32'(count), 32'd0);

    // Forwarding picks the youngest match; register 0 never hits.
    @(negedge clk) wb_stall = 1'b1;
    do_push(5'd7, 32'h11);
    do_push(5'd7, 32'h22);
    rq_addr1 = 5'd7; rq_addr2 = 5'd0;
    #1;
    chk("t3_hit1", 32'(rq_hit1), 32'd1);
    chk("t3_data1", rq_data1, 32'h22);
    chk("t3_hit2_r0", 32'(rq_hit2), 32'd0);
    chk("t3_data2_r0", rq_data2, 32'd0);
    @(negedge clk) wb_stall = 1'b0;
    @(negedge clk);
    chk("t3_hit1_mixed", 32'(rq_hit1), 32'd1);
    chk("t3_data1_mixed", rq_data1, 32'h22);
    @(negedge clk);
    chk("t3_hit1_outreg", 32'(rq_hit1), 32'd1);
    chk("t3_data1_outreg", rq_data1, 32'h22);
    @(negedge clk);
    chk("t3_hit1_gone", 32'(rq_hit1), 32'd0);
    chk("t3_data1_gone", rq_data1, 32'd0);

    // Writes to register 0 complete the handshake but are discarded.
    for (int i = 0; i < 3; i++) begin
      do_push(5'd0, 32'hFF);
      chk("t4_count_zero", 32'(count), 32'd0);
    end
    chk("t4_dropped", 32'(dropped), 32'd3);
    repeat (3) @(negedge clk);

    // Flush with a concurrent request.
    @(negedge clk) wb_stall = 1'b1;
    for (int i = 1; i <= 3; i++) do_push(ADDR_W'(i), 32'hA0 + 32'(i));
    chk("t5_count_pre", 32'(count), 32'd3);
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_addr = 5'd8; req_data = 32'h88;
    #1 chk("t5_ready_flush", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    sb_q.delete();
    chk("t5_count_flushed", 32'(count), 32'd0);
    wb_stall = 1'b0; rq_addr1 = 5'd1; rq_addr2 = 5'd3;
    #1;
    chk("t5_hit1", 32'(rq_hit1), 32'd0);
    chk("t5_hit2", 32'(rq_hit2), 32'd0);
    repeat (4) @(negedge clk);
    chk("t5_count_idle", 32'(count), 32'd0);

    // Asynchronous reset while a write is in flight.
    @(negedge clk) wb_stall = 1'b1;
    do_push(5'd10, 32'hA);
    do_push(5'd11, 32'hB);
    do_push(5'd12, 32'hC);
    @(negedge clk) wb_stall = 1'b0;
    @(negedge clk) chk("t6_we_pre", 32'(we), 32'd1);
    rq_addr1 = 5'd11;
    #2 reset = 1'b1;
    #1;
    chk("t6_we_reset", 32'(we), 32'd0);
    chk("t6_count_reset", 32'(count), 32'd0);
    chk("t6_hit_reset", 32'(rq_hit1), 32'd0);
    chk("t6_dropped_reset", 32'(dropped), 32'd0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    do_push(5'd9, 32'h99);
    repeat (3) @(negedge clk);
    chk("t6_count_end", 32'(count), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
